// File: rtl/axi4_lite_7segs_scan.sv
// AXI4-Lite slave holding G_NB_DIGITS digit registers and driving one
// time-multiplexed 7-segment bus with active-low digit enables.
module axi4_lite_7segs_scan #(
    parameter int G_AXI4_LITE_ADDR_WIDTH = 8,
    parameter int G_AXI4_LITE_DATA_WIDTH = 32,
    parameter int G_NB_DIGITS            = 8,
    parameter int G_SCAN_DIV             = 1000,
    parameter int G_BLINK_DIV            = 25000000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              awvalid,
    input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]                        awprot,
    output logic                              awready,
    input  logic                              wvalid,
    input  logic [G_AXI4_LITE_DATA_WIDTH-1:0] wdata,
    input  logic [3:0]                        wstrb,
    output logic                              wready,
    output logic                              bvalid,
    input  logic                              bready,
    output logic [1:0]                        bresp,
    input  logic                              arvalid,
    input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]                        arprot,
    output logic                              arready,
    output logic                              rvalid,
    input  logic                              rready,
    output logic [G_AXI4_LITE_DATA_WIDTH-1:0] rdata,
    output logic [1:0]                        rresp,
    output logic [6:0]                        o_seg,
    output logic                              o_dp,
    output logic [G_NB_DIGITS-1:0]            o_an
);

    localparam int AW      = G_AXI4_LITE_ADDR_WIDTH;
    localparam int N       = G_NB_DIGITS;
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam int SCAN_W  = $clog2(G_SCAN_DIV);
    localparam int BLINK_W = $clog2(G_BLINK_DIV);

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(G_SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(G_BLINK_DIV - 1);
    localparam logic [16:0]        DIGIT_MASK = 17'h1FF0F;
    localparam logic [1:0]         RESP_OKAY   = 2'b00;
    localparam logic [1:0]         RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_BLINK,
        SEL_STATUS,
        SEL_DIGIT
    } sel_kind_e;

    typedef struct packed {
        sel_kind_e  kind;
        logic [3:0] idx;
    } sel_t;

    function automatic sel_t decode(input logic [AW-1:0] addr);
        sel_t s;
        s.kind = SEL_NONE;
        s.idx  = addr[5:2];
        if (addr[AW-1:2] == (AW-2)'(0))
            s.kind = SEL_CTRL;
        else if (addr[AW-1:2] == (AW-2)'(1))
            s.kind = SEL_BLINK;
        else if (addr[AW-1:2] == (AW-2)'(2))
            s.kind = SEL_STATUS;
        else if (addr[AW-1:6] == (AW-6)'(1) && {1'b0, addr[5:2]} < 5'(N))
            s.kind = SEL_DIGIT;
        return s;
    endfunction

    function automatic logic [6:0] seg_hex(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic               en_q, en_d;
    logic [N-1:0]       blink_mask_q, blink_mask_d;
    logic [16:0]        digit_q [N];
    logic [16:0]        digit_d [N];
    logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_off_q, blink_off_d;
    logic               bvalid_q, bvalid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic               rvalid_q, rvalid_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [N-1:0]       an_q, an_d;

    logic        wr_acc, rd_acc;
    sel_t        wr_sel, rd_sel;
    logic [31:0] wmask, wr_base, wr_word;
    logic [16:0] cur_digit;
    logic        unused_prot;

    assign unused_prot = ^{awprot, arprot};

    // Ready is combinational so the accept pulse lands in the same cycle as valid.
    assign wr_acc  = awvalid & wvalid & ~bvalid_q;
    assign rd_acc  = arvalid & ~rvalid_q;
    assign wr_sel  = decode(awaddr);
    assign rd_sel  = decode(araddr);
    assign wmask   = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    assign cur_digit = digit_q[scan_idx_q];

    // NOTE: every variable gets its default first so no path infers a latch.
    always_comb begin
        en_d         = en_q;
        blink_mask_d = blink_mask_q;
        digit_d      = digit_q;
        scan_idx_d   = scan_idx_q;
        scan_cnt_d   = scan_cnt_q + 1'b1;
        blink_cnt_d  = blink_cnt_q + 1'b1;
        blink_off_d  = blink_off_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        rvalid_d     = rvalid_q;
        rresp_d      = rresp_q;
        rdata_d      = rdata_q;
        wr_base      = '0;
        seg_d        = 7'h7F;
        dp_d         = 1'b1;
        an_d         = '1;

        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
        end
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
        end

        case (wr_sel.kind)
            SEL_CTRL:  wr_base = {31'b0, en_q};
            SEL_BLINK: wr_base = 32'(blink_mask_q);
            SEL_DIGIT: wr_base = 32'(digit_q[wr_sel.idx[IDX_W-1:0]]);
            default:   wr_base = '0;
        endcase
        wr_word = (wr_base & ~wmask) | (32'(wdata) & wmask);

        if (wr_acc) begin
            bvalid_d = 1'b1;
            bresp_d  = (wr_sel.kind == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
            case (wr_sel.kind)
                SEL_CTRL:  en_d = wr_word[0];
                SEL_BLINK: blink_mask_d = wr_word[N-1:0];
                SEL_DIGIT: digit_d[wr_sel.idx[IDX_W-1:0]] = wr_word[16:0] & DIGIT_MASK;
                default:   ;
            endcase
        end else if (bready) begin
            bvalid_d = 1'b0;
        end

        // Read data comes from the pre-edge state, so a same-cycle write is not visible.
        if (rd_acc) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            case (rd_sel.kind)
                SEL_CTRL:   rdata_d = {31'b0, en_q};
                SEL_BLINK:  rdata_d = 32'(blink_mask_q);
                SEL_STATUS: rdata_d = {23'b0, blink_off_q, 4'b0, 4'(scan_idx_q)};
                SEL_DIGIT:  rdata_d = 32'(digit_q[rd_sel.idx[IDX_W-1:0]]);
                default: begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end
            endcase
        end else if (rready) begin
            rvalid_d = 1'b0;
        end

        if (en_q) begin
            an_d = ~(N'(1) << scan_idx_q);
            if (!(blink_mask_q[scan_idx_q] && blink_off_q)) begin
                seg_d = cur_digit[16] ? ~cur_digit[14:8] : seg_hex(cur_digit[3:0]);
                dp_d  = ~cur_digit[15];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q         <= 1'b0;
            blink_mask_q <= '0;
            // NOTE: the digit file is small and must read back 0 after reset, so it is reset.
            for (int k = 0; k < N; k++) digit_q[k] <= '0;
            scan_idx_q   <= '0;
            scan_cnt_q   <= '0;
            blink_cnt_q  <= '0;
            blink_off_q  <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            rvalid_q     <= 1'b0;
            rresp_q      <= RESP_OKAY;
            rdata_q      <= '0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
        end else begin
            en_q         <= en_d;
            blink_mask_q <= blink_mask_d;
            digit_q      <= digit_d;
            scan_idx_q   <= scan_idx_d;
            scan_cnt_q   <= scan_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_off_q  <= blink_off_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rvalid_q     <= rvalid_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign awready = wr_acc;
    assign wready  = wr_acc;
    assign arready = rd_acc;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = G_AXI4_LITE_DATA_WIDTH'(rdata_q);
    assign o_seg   = seg_q;
    assign o_dp    = dp_q;
    assign o_an    = an_q;

endmodule
